trail_pixel_decoder: RTL and testbench

- Unpacks the packed Y/Cb/Cr history pixel produced by the trail IIR stage and stored in the frame buffer, and converts it to RGB888 for the display/HDMI path.
- Sits between the frame-buffer read port and the display pixel pipeline.
- 3-stage pipeline with valid/ready flow control; pixel coordinates travel alongside the data as sideband.

---
 rtl/trail_pixel_decoder.sv | 200 ++++++++++++++++++++
 tb/tb_trail_pixel_decoder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trail_pixel_decoder.sv
// trail_pixel_decoder: unpacks the packed {Y,Cb,Cr} trail history pixel read
// from the frame buffer and converts it to RGB888. Three register stages
// (unpack, chroma products, sum/clamp) share one stall signal, so a full
// pipeline freezes as a unit and drains back-to-back once released.
module trail_pixel_decoder #(
    parameter int Y_BITS      = 4,
    parameter int CB_BITS     = 2,
    parameter int CR_BITS     = 2,
    parameter int COLOR_DEPTH = 8,
    parameter int H_BITS      = 11,
    parameter int V_BITS      = 10
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [COLOR_DEPTH-1:0] pixel_in,
    input  logic [H_BITS-1:0]      hcount_in,
    input  logic [V_BITS-1:0]      vcount_in,
    input  logic                   gray_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    output logic [23:0]            rgb_out,
    output logic [H_BITS-1:0]      hcount_out,
    output logic [V_BITS-1:0]      vcount_out,
    output logic                   valid_out,
    input  logic                   ready_in
);

    // 2-bit chroma code to signed offset: 0,1,2,3 -> -96,-32,+32,+96
    function automatic logic signed [8:0] chroma_offset(input logic [1:0] code);
        logic signed [8:0] off;
        case (code)
            2'd0:    off = -9'sd96;
            2'd1:    off = -9'sd32;
            2'd2:    off = 9'sd32;
            default: off = 9'sd96;
        endcase
        return off;
    endfunction

    // Saturate a signed channel sum into 0..255
    function automatic logic [7:0] clamp8(input logic signed [10:0] v);
        logic [7:0] c;
        if (v < 0)
            c = 8'd0;
        else if (v > 11'sd255)
            c = 8'd255;
        else
            c = v[7:0];
        return c;
    endfunction

    logic stall;
    logic advance;

    // Stage 1 registers: unpacked luma and chroma offsets
    logic                    s1_valid;
    logic [7:0]              s1_y8;
    logic signed [8:0]       s1_cb;
    logic signed [8:0]       s1_cr;
    logic                    s1_gray;
    logic [H_BITS-1:0]       s1_h;
    logic [V_BITS-1:0]       s1_v;

    // Stage 2 registers: chroma products
    logic                    s2_valid;
    logic [7:0]              s2_y8;
    logic signed [17:0]      s2_pr;
    logic signed [17:0]      s2_pg;
    logic signed [17:0]      s2_pb;
    logic                    s2_gray;
    logic [H_BITS-1:0]       s2_h;
    logic [V_BITS-1:0]       s2_v;

    // Stage 3 registers: final RGB
    logic                    s3_valid;
    logic [23:0]             s3_rgb;
    logic [H_BITS-1:0]       s3_h;
    logic [V_BITS-1:0]       s3_v;

    // Combinational intermediates
    logic [Y_BITS-1:0]       y_field;
    logic [7:0]              y8_c;
    logic signed [8:0]       cb_c;
    logic signed [8:0]       cr_c;
    logic signed [17:0]      cb_ext;
    logic signed [17:0]      cr_ext;
    logic signed [17:0]      pr_c;
    logic signed [17:0]      pg_c;
    logic signed [17:0]      pb_c;
    logic signed [17:0]      pr_sh;
    logic signed [17:0]      pg_sh;
    logic signed [17:0]      pb_sh;
    logic signed [10:0]      y_ext;
    logic signed [10:0]      r_sum;
    logic signed [10:0]      g_sum;
    logic signed [10:0]      b_sum;
    logic [23:0]             rgb_c;

    // Whole-pipeline stall: only a held, unaccepted output blocks movement
    assign stall     = s3_valid && !ready_in;
    assign advance   = !stall;
    assign ready_out = !stall;

    // Unpack: luma widened by bit replication so 0xF maps to full scale
    always_comb begin
        y_field = pixel_in[COLOR_DEPTH-1 -: Y_BITS];
        y8_c    = {y_field, y_field};
        cb_c    = chroma_offset(pixel_in[CR_BITS +: 2]);
        cr_c    = chroma_offset(pixel_in[1:0]);
    end

    // Stage 1 register: capture unpacked pixel and sideband
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s1_valid <= 1'b0;
            s1_y8    <= '0;
            s1_cb    <= '0;
            s1_cr    <= '0;
            s1_gray  <= 1'b0;
            s1_h     <= '0;
            s1_v     <= '0;
        end else if (advance) begin
            s1_valid <= valid_in;
            s1_y8    <= y8_c;
            s1_cb    <= cb_c;
            s1_cr    <= cr_c;
            s1_gray  <= gray_in;
            s1_h     <= hcount_in;
            s1_v     <= vcount_in;
        end
    end

    // Chroma products in 18-bit signed arithmetic
    always_comb begin
        cb_ext = {{9{s1_cb[8]}}, s1_cb};
        cr_ext = {{9{s1_cr[8]}}, s1_cr};
        pr_c   = 18'sd359 * cr_ext;
        pg_c   = 18'sd88 * cb_ext + 18'sd183 * cr_ext;
        pb_c   = 18'sd454 * cb_ext;
    end

    // Stage 2 register: products alongside luma and sideband
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s2_valid <= 1'b0;
            s2_y8    <= '0;
            s2_pr    <= '0;
            s2_pg    <= '0;
            s2_pb    <= '0;
            s2_gray  <= 1'b0;
            s2_h     <= '0;
            s2_v     <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_y8    <= s1_y8;
            s2_pr    <= pr_c;
            s2_pg    <= pg_c;
            s2_pb    <= pb_c;
            s2_gray  <= s1_gray;
            s2_h     <= s1_h;
            s2_v     <= s1_v;
        end
    end

    // Sum and clamp; arithmetic shift floors negative terms toward -inf
    always_comb begin
        pr_sh = s2_pr >>> 8;
        pg_sh = s2_pg >>> 8;
        pb_sh = s2_pb >>> 8;
        y_ext = $signed({3'b000, s2_y8});
        r_sum = y_ext + $signed(pr_sh[10:0]);
        g_sum = y_ext - $signed(pg_sh[10:0]);
        b_sum = y_ext + $signed(pb_sh[10:0]);
        if (s2_gray)
            rgb_c = {s2_y8, s2_y8, s2_y8};
        else
            rgb_c = {clamp8(r_sum), clamp8(g_sum), clamp8(b_sum)};
    end

    // Stage 3 register: output holding register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s3_valid <= 1'b0;
            s3_rgb   <= '0;
            s3_h     <= '0;
            s3_v     <= '0;
        end else if (advance) begin
            s3_valid <= s2_valid;
            s3_rgb   <= rgb_c;
            s3_h     <= s2_h;
            s3_v     <= s2_v;
        end
    end

    assign valid_out  = s3_valid;
    assign rgb_out    = s3_rgb;
    assign hcount_out = s3_h;
    assign vcount_out = s3_v;

endmodule

// File: tb/tb_trail_pixel_decoder.sv
// Testbench for trail_pixel_decoder: directed and randomized stimulus, checked
// against an arithmetic reference model and an expected-output queue.
module tb_trail_pixel_decoder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [7:0]  pixel_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        gray_in;
    logic        valid_in;
    logic        ready_out;
    logic [23:0] rgb_out;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        valid_out;
    logic        ready_in;

    trail_pixel_decoder #(
        .Y_BITS(4), .CB_BITS(2), .CR_BITS(2), .COLOR_DEPTH(8), .H_BITS(11), .V_BITS(10)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .pixel_in(pixel_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .gray_in(gray_in),
        .valid_in(valid_in), .ready_out(ready_out), .rgb_out(rgb_out),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .valid_out(valid_out), .ready_in(ready_in)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [23:0] rgb;
        logic [10:0] h;
        logic [9:0]  v;
    } exp_t;

    exp_t        exp_q[$];
    int          out_cycles[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          cyc        = 0;
    bit          prev_stall = 0;
    logic [44:0] prev_word;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int fdiv256(input int x);
        if (x >= 0) return x / 256;
        return -((-x + 255) / 256);
    endfunction

    function automatic int sat(input int x);
        if (x < 0) return 0;
        if (x > 255) return 255;
        return x;
    endfunction

    // Reference: conversion written directly from the channel equations
    function automatic exp_t model(input logic [7:0] p, input logic g,
                                   input logic [10:0] h, input logic [9:0] v);
        exp_t e;
        int y, cb, cr, r, gg, b;
        y  = int'(p[7:4]) * 17;
        cb = int'(p[3:2]) * 64 - 96;
        cr = int'(p[1:0]) * 64 - 96;
        if (g) begin
            r = y; gg = y; b = y;
        end else begin
            r  = sat(y + fdiv256(359 * cr));
            gg = sat(y - fdiv256(88 * cb + 183 * cr));
            b  = sat(y + fdiv256(454 * cb));
        end
        e.rgb = {r[7:0], gg[7:0], b[7:0]};
        e.h = h;
        e.v = v;
        return e;
    endfunction

    // One clock: called at a negedge with inputs already driven
    task automatic tick();
        exp_t e;
        #1;
        if (rst_in) begin
            check("ready_rule", {63'd0, ready_out}, {63'd0, !(valid_out && !ready_in)});
            if (prev_stall) begin
                check("hold_valid", {63'd0, valid_out}, 64'd1);
                check("hold_data", {19'd0, rgb_out, hcount_out, vcount_out}, {19'd0, prev_word});
            end
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", {63'd0, valid_out}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rgb", {40'd0, rgb_out}, {40'd0, e.rgb});
                    check("hcount", {53'd0, hcount_out}, {53'd0, e.h});
                    check("vcount", {54'd0, vcount_out}, {54'd0, e.v});
                    out_cycles.push_back(cyc);
                end
            end
            if (valid_in && ready_out)
                exp_q.push_back(model(pixel_in, gray_in, hcount_in, vcount_in));
            prev_stall = valid_out && !ready_in;
            prev_word  = {rgb_out, hcount_out, vcount_out};
        end else begin
            prev_stall = 0;
        end
        @(negedge clk_in);
        cyc++;
    endtask

    task automatic drain();
        valid_in = 1'b0;
        ready_in = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            tick();
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic drive(input logic [7:0] p, input logic g, input logic [10:0] h, input logic [9:0] v);
        pixel_in  = p;
        gray_in   = g;
        hcount_in = h;
        vcount_in = v;
    endtask

    // Lone pixel: accepted, invisible for two cycles, present on the third
    task automatic single(input string tag, input logic [7:0] p, input logic g,
                          input logic [23:0] exp_rgb, input logic [10:0] h, input logic [9:0] v);
        drive(p, g, h, v);
        valid_in = 1'b1;
        ready_in = 1'b1;
        #1;
        check({tag, "_ready"}, {63'd0, ready_out}, 64'd1);
        tick();
        valid_in = 1'b0;
        check({tag, "_lat1"}, {63'd0, valid_out}, 64'd0);
        tick();
        check({tag, "_lat2"}, {63'd0, valid_out}, 64'd0);
        tick();
        check({tag, "_lat3"}, {63'd0, valid_out}, 64'd1);
        check({tag, "_rgb"}, {40'd0, rgb_out}, {40'd0, exp_rgb});
        check({tag, "_h"}, {53'd0, hcount_out}, {53'd0, h});
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_in   = 1'b0;
        valid_in = 1'b1;
        ready_in = 1'b1;
        drive(8'hFA, 1'b0, 11'd5, 10'd5);

        // Reset held with an offer present
        @(negedge clk_in);
        @(negedge clk_in);
        check("rst_valid", {63'd0, valid_out}, 64'd0);
        check("rst_rgb", {40'd0, rgb_out}, 64'd0);
        check("rst_h", {53'd0, hcount_out}, 64'd0);
        valid_in = 1'b0;
        rst_in   = 1'b1;
        #1;
        check("rel_ready", {63'd0, ready_out}, 64'd1);
        @(negedge clk_in);

        // Directed conversions, including extreme sideband values
        single("fa", 8'hFA, 1'b0, 24'hFFDEFF, 11'd2047, 10'd1023);
        single("00", 8'h00, 1'b0, 24'h006600, 11'd0, 10'd0);
        single("86", 8'h86, 1'b0, 24'hB47D4F, 11'd100, 10'd7);
        single("gray", 8'h86, 1'b1, 24'h888888, 11'd101, 10'd7);

        // 16-pixel burst with hcount 0..15
        out_cycles.delete();
        for (int i = 0; i < 16; i++) begin
            drive(8'($urandom), 1'b0, 11'(i), 10'd3);
            valid_in = 1'b1;
            tick();
        end
        drain();
        check("burst_count", 64'(out_cycles.size()), 64'd16);
        if (out_cycles.size() == 16)
            check("burst_back2back", 64'(out_cycles[15] - out_cycles[0]), 64'd15);

        // Backpressure mid-burst; offers during the stall must not be taken
        for (int i = 0; i < 16; i++) begin
            drive(8'($urandom), 1'($urandom), 11'(200 + i), 10'd9);
            valid_in = 1'b1;
            ready_in = !(i >= 5 && i < 10);
            if (!ready_in) begin
                #1;
                check("bp_ready", {63'd0, ready_out}, 64'd0);
            end
            tick();
        end
        drain();

        // valid_in toggling every cycle
        out_cycles.delete();
        for (int i = 0; i < 20; i++) begin
            drive(8'($urandom), 1'b0, 11'(300 + i), 10'd1);
            valid_in = (i % 2 == 0);
            tick();
        end
        drain();
        check("toggle_count", 64'(out_cycles.size()), 64'd10);

        // Randomized traffic and backpressure
        for (int i = 0; i < 400; i++) begin
            drive(8'($urandom), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0) ? 11'd2047 : 11'($urandom),
                  10'($urandom));
            valid_in = 1'($urandom_range(0, 1));
            ready_in = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // Reset with three pixels in flight
        for (int i = 0; i < 3; i++) begin
            drive(8'($urandom), 1'b0, 11'(500 + i), 10'd2);
            valid_in = 1'b1;
            tick();
        end
        valid_in = 1'b0;
        check("inflight_valid", {63'd0, valid_out}, 64'd1);
        #2;
        rst_in = 1'b0;
        #1;
        check("async_valid", {63'd0, valid_out}, 64'd0);
        check("async_rgb", {40'd0, rgb_out}, 64'd0);
        check("async_h", {53'd0, hcount_out}, 64'd0);
        exp_q.delete();
        prev_stall = 0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        check("rel2_ready", {63'd0, ready_out}, 64'd1);
        @(negedge clk_in);
        single("post_rst", 8'h86, 1'b0, 24'hB47D4F, 11'd777, 10'd3);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
